dispatch_unit: RTL

Producer side of the issue-queue interface. Takes renamed micro-ops from rename, allocates a reorder-buffer entry for each, and buffers them in a 2-entry skid FIFO. It then presents them to the issue queue one per cycle, honouring the queue's stall. It also tracks ROB occupancy from commit and recovers on pipeline flush.

---
 rtl/dispatch_unit_pkg.sv | 36 +++
 rtl/dispatch_unit_if.sv | 24 ++
 rtl/dispatch_unit_fifo.sv | 61 ++++++
 rtl/dispatch_unit.sv | 125 ++++++++++++
 4 files changed

// File: rtl/dispatch_unit_pkg.sv
// Shared dispatch / issue-queue types: ROB and register geometry, the
// buffered entry layout and the dispatch FSM state encoding.
package dispatch_unit_pkg;

  localparam int ROB_SIZE      = 16;
  localparam int ROB_SIZE_LOG2 = 4;
  localparam int NUM_REG_LOG2  = 6;
  localparam int REG_W         = NUM_REG_LOG2 + 1;
  localparam int REG_SIZE      = 1 << REG_W;
  localparam int UOP_W         = 5;
  localparam int IMM_W         = 32;
  localparam int BUF_DEPTH     = 2;

  typedef logic [REG_W-1:0]         preg_t;
  typedef logic [ROB_SIZE_LOG2-1:0] rob_idx_t;

  typedef struct packed {
    logic [UOP_W-1:0] uop;
    preg_t            prs1;
    preg_t            prs2;
    preg_t            prd;
    logic [IMM_W-1:0] imm;
    rob_idx_t         rob_index;
  } dispatch_entry_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } dispatch_state_t;

  // ROB pointers wrap naturally because ROB_SIZE is a power of two.
  function automatic rob_idx_t rob_inc(input rob_idx_t idx);
    return idx + rob_idx_t'(1);
  endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// Dispatch -> issue-queue bus. The dispatch unit is the master: it presents
// a uop with iq_valid and the queue pushes back with iq_stall.
interface dispatch_unit_if;
  import dispatch_unit_pkg::*;

  logic             iq_valid;
  logic             iq_stall;
  rob_idx_t         iq_rob_index;
  logic [UOP_W-1:0] iq_uop;
  preg_t            iq_prs1;
  preg_t            iq_prs2;
  preg_t            iq_prd;
  logic [IMM_W-1:0] iq_imm;

  modport master (
    output iq_valid, iq_rob_index, iq_uop, iq_prs1, iq_prs2, iq_prd, iq_imm,
    input  iq_stall
  );

  modport slave (
    input  iq_valid, iq_rob_index, iq_uop, iq_prs1, iq_prs2, iq_prd, iq_imm,
    output iq_stall
  );
endinterface

// File: rtl/dispatch_unit_fifo.sv
// Small circular skid FIFO of dispatch entries. Push into a full FIFO and
// pop from an empty FIFO are ignored; clear empties it in one cycle.
// The storage is reset so the head reads as zero straight out of reset.
module dispatch_fifo
  import dispatch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  dispatch_entry_t         wdata,
  output dispatch_entry_t         rdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  dispatch_entry_t  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointer, occupancy and storage update; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: allocates a ROB slot for each renamed uop, buffers it in a
// skid FIFO and presents it to the issue queue, tracking ROB occupancy from
// commit and recovering from a pipeline flush.
// Optional feature: define DISPATCH_STATS_EN to add the stall_cycles counter.
module dispatch_unit
  import dispatch_unit_pkg::*;
#(
  parameter int BUF_DEPTH = dispatch_unit_pkg::BUF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ren_valid,
  output logic                   ren_ready,
  input  logic [UOP_W-1:0]       ren_uop,
  input  preg_t                  ren_prs1,
  input  preg_t                  ren_prs2,
  input  preg_t                  ren_prd,
  input  logic [IMM_W-1:0]       ren_imm,
  dispatch_unit_if.master        iq,
  input  logic                   commit_valid,
  input  logic                   flush,
  output logic [ROB_SIZE_LOG2:0] rob_count
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int RCW   = ROB_SIZE_LOG2 + 1;

  dispatch_state_t  state;
  rob_idx_t         rob_head;
  rob_idx_t         rob_tail;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  dispatch_entry_t  push_entry;
  dispatch_entry_t  head_entry;
  logic             run;
  logic             accept;
  logic             issue;
  logic             commit_ok;

  // Ready only looks at registered state, so a pop in the same cycle as a
  // full FIFO does not reopen the rename handshake until the next cycle.
  assign run       = (state == RUN);
  assign ren_ready = run && (fifo_count < CNT_W'(BUF_DEPTH)) &&
                     (rob_count < RCW'(ROB_SIZE));
  assign accept    = ren_valid && ren_ready && !flush;
  assign commit_ok = commit_valid && (rob_count != '0) && !flush;

  assign iq.iq_valid = run && !fifo_empty;
  assign issue       = iq.iq_valid && !iq.iq_stall;

  assign push_entry.uop       = ren_uop;
  assign push_entry.prs1      = ren_prs1;
  assign push_entry.prs2      = ren_prs2;
  assign push_entry.prd       = ren_prd;
  assign push_entry.imm       = ren_imm;
  assign push_entry.rob_index = rob_tail;

  dispatch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (issue),
    .clear (flush),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // The head entry drives the queue directly, so it stays put while stalled.
  assign iq.iq_uop       = head_entry.uop;
  assign iq.iq_prs1      = head_entry.prs1;
  assign iq.iq_prs2      = head_entry.prs2;
  assign iq.iq_prd       = head_entry.prd;
  assign iq.iq_imm       = head_entry.imm;
  assign iq.iq_rob_index = head_entry.rob_index;

  // Run/recover FSM with ROB head/tail pointers and the live-entry count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      rob_head  <= '0;
      rob_tail  <= '0;
      rob_count <= '0;
    end else begin
      case (state)
        RUN:     state <= flush ? RECOVER : RUN;
        RECOVER: state <= flush ? RECOVER : RUN;
        default: state <= RUN;
      endcase
      if (flush) begin
        rob_tail  <= rob_head;
        rob_count <= '0;
      end else begin
        if (accept)    rob_tail <= rob_inc(rob_tail);
        if (commit_ok) rob_head <= rob_inc(rob_head);
        case ({accept, commit_ok})
          2'b10:   rob_count <= rob_count + RCW'(1);
          2'b01:   rob_count <= rob_count - RCW'(1);
          default: rob_count <= rob_count;
        endcase
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Count cycles a valid uop sits stalled; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (iq.iq_valid && iq.iq_stall) begin
      stall_cycles <= sat_inc32(stall_cycles);
    end
  end
`endif

endmodule
